// File: rtl/bridge_arbiter_pkg.sv
// Shared widths, FSM states and the bridge request record for the
// two-requester SDRAM bridge arbiter.
package bridge_arbiter_pkg;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byte_enable;
    logic [DATA_W-1:0] write_data;
    logic              read;
    logic              write;
  } bus_req_t;

  // A requester raising read and write together is issued as a write only.
  function automatic bus_req_t make_req(
    input logic [ADDR_W-1:0] address,
    input logic [BE_W-1:0]   byte_enable,
    input logic [DATA_W-1:0] write_data,
    input logic              read,
    input logic              write
  );
    bus_req_t r;
    r.address     = address;
    r.byte_enable = byte_enable;
    r.write_data  = write_data;
    r.read        = read & ~write;
    r.write       = write;
    return r;
  endfunction

endpackage

// File: rtl/bridge_timeout_counter.sv
// Counts bridge cycles of the current transfer and flags when the
// abort threshold has been reached.
module bridge_timeout_counter #(
  parameter int TERMINAL = 255,
  localparam int W = $clog2(TERMINAL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign terminal = (count == W'(TERMINAL));

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing one SDRAM bridge between two requesters,
// with a per-transfer timeout that completes the transfer with an error.
module bridge_arbiter
  import bridge_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byte_enable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_write_data,
  output logic              m0_acknowledge,
  output logic              m0_error,
  output logic [DATA_W-1:0] m0_read_data,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byte_enable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_write_data,
  output logic              m1_acknowledge,
  output logic              m1_error,
  output logic [DATA_W-1:0] m1_read_data,

  output logic [ADDR_W-1:0] bridge_memory_address,
  output logic [BE_W-1:0]   bridge_memory_byte_enable,
  output logic              bridge_memory_read,
  output logic              bridge_memory_write,
  output logic [DATA_W-1:0] bridge_memory_write_data,
  input  logic              bridge_memory_acknowledge,
  input  logic [DATA_W-1:0] bridge_memory_read_data
);

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic              owner;
  logic              grant_valid;
  logic              grant_sel;
  logic              finish_ok;
  logic              finish_timeout;
  logic              terminal;
  logic              cnt_clear;
  logic              cnt_enable;
  bus_req_t          req0;
  bus_req_t          req1;
  bus_req_t          bus;
  logic [DATA_W-1:0] read_result;

  assign req0 = make_req(m0_address, m0_byte_enable, m0_write_data, m0_read, m0_write);
  assign req1 = make_req(m1_address, m1_byte_enable, m1_write_data, m1_read, m1_write);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants only from IDLE; on contention the requester not served last wins.
  // In BUSY an acknowledge takes priority over a timeout in the same cycle.
  always_comb begin
    state_next     = state;
    grant_valid    = 1'b0;
    grant_sel      = 1'b0;
    finish_ok      = 1'b0;
    finish_timeout = 1'b0;
    case (state)
      IDLE: begin
        if ((req0.read | req0.write) || (req1.read | req1.write)) begin
          grant_valid = 1'b1;
          if ((req0.read | req0.write) && (req1.read | req1.write)) begin
            grant_sel = ~last_grant;
          end else begin
            grant_sel = req1.read | req1.write;
          end
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (bridge_memory_acknowledge) begin
          finish_ok  = 1'b1;
          state_next = DONE;
        end else if (terminal) begin
          finish_timeout = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The count reads 1 in the first BUSY cycle, so terminal marks the last
  // cycle a transfer may stay on the bridge.
  assign cnt_clear  = (state != BUSY) && !grant_valid;
  assign cnt_enable = grant_valid || ((state == BUSY) && !terminal);

  bridge_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (terminal)
  );

  assign read_result = (finish_ok && bus.read) ? bridge_memory_read_data : '0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bus            <= '0;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      m0_acknowledge <= 1'b0;
      m0_error       <= 1'b0;
      m0_read_data   <= '0;
      m1_acknowledge <= 1'b0;
      m1_error       <= 1'b0;
      m1_read_data   <= '0;
    end else begin
      m0_acknowledge <= 1'b0;
      m0_error       <= 1'b0;
      m1_acknowledge <= 1'b0;
      m1_error       <= 1'b0;
      if (grant_valid) begin
        bus        <= grant_sel ? req1 : req0;
        owner      <= grant_sel;
        last_grant <= grant_sel;
      end
      if (finish_ok || finish_timeout) begin
        bus.read  <= 1'b0;
        bus.write <= 1'b0;
        if (owner) begin
          m1_acknowledge <= 1'b1;
          m1_error       <= finish_timeout;
          m1_read_data   <= read_result;
        end else begin
          m0_acknowledge <= 1'b1;
          m0_error       <= finish_timeout;
          m0_read_data   <= read_result;
        end
      end
    end
  end

  assign bridge_memory_address     = bus.address;
  assign bridge_memory_byte_enable = bus.byte_enable;
  assign bridge_memory_write_data  = bus.write_data;
  assign bridge_memory_read        = bus.read;
  assign bridge_memory_write       = bus.write;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter: directed scenarios plus random
// two-requester traffic against a transaction-level reference model.
module tb_bridge_arbiter;

  localparam int T = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0][26:0]  m_address;
  logic [1:0][1:0]   m_be;
  logic [1:0]        m_read;
  logic [1:0]        m_write;
  logic [1:0][15:0]  m_wdata;
  logic              m0_ack, m1_ack, m0_err, m1_err;
  logic [15:0]       m0_rd, m1_rd;
  logic [1:0]        m_ack;
  logic [1:0]        m_err;
  logic [1:0][15:0]  m_rdata;
  logic [26:0]       b_addr;
  logic [1:0]        b_be;
  logic              b_read, b_write;
  logic [15:0]       b_wdata;
  logic              b_ack;
  logic [15:0]       b_rdata;

  assign m_ack   = {m1_ack, m0_ack};
  assign m_err   = {m1_err, m0_err};
  assign m_rdata = {m1_rd, m0_rd};

  bridge_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_clk                   (clk),
    .reset_reset_n             (rst_n),
    .m0_address                (m_address[0]),
    .m0_byte_enable            (m_be[0]),
    .m0_read                   (m_read[0]),
    .m0_write                  (m_write[0]),
    .m0_write_data             (m_wdata[0]),
    .m0_acknowledge            (m0_ack),
    .m0_error                  (m0_err),
    .m0_read_data              (m0_rd),
    .m1_address                (m_address[1]),
    .m1_byte_enable            (m_be[1]),
    .m1_read                   (m_read[1]),
    .m1_write                  (m_write[1]),
    .m1_write_data             (m_wdata[1]),
    .m1_acknowledge            (m1_ack),
    .m1_error                  (m1_err),
    .m1_read_data              (m1_rd),
    .bridge_memory_address     (b_addr),
    .bridge_memory_byte_enable (b_be),
    .bridge_memory_read        (b_read),
    .bridge_memory_write       (b_write),
    .bridge_memory_write_data  (b_wdata),
    .bridge_memory_acknowledge (b_ack),
    .bridge_memory_read_data   (b_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [26:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] rdata;
  } xact_t;

  xact_t       pend0[$];
  xact_t       pend1[$];
  xact_t       cur [2];
  bit          active [2];
  int          holdoff [2];
  bit          req_drv [2];
  logic [15:0] exp_rdata [2];
  int          owner;
  int          strobe_cnt;
  int          last_served;
  int          max_gap;
  int          served_order[$];
  int          compared = 0;
  int          mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic xact_t mkXact(input logic rd, input logic wr, input logic [26:0] addr,
                                   input logic [1:0] be, input logic [15:0] wdata,
                                   input int delay, input logic [15:0] rdata);
    xact_t x;
    x.rd = rd; x.wr = wr; x.addr = addr; x.be = be;
    x.wdata = wdata; x.delay = delay; x.rdata = rdata;
    return x;
  endfunction

  function automatic xact_t randXact();
    int kind = $urandom_range(0, 2);
    return mkXact(kind != 1, kind != 0, 27'($urandom), 2'($urandom), 16'($urandom),
                  $urandom_range(1, T + 3), 16'($urandom));
  endfunction

  // Expected bridge bus for a transaction: write wins over read.
  function automatic logic [46:0] busOf(input xact_t x);
    return {x.addr, x.be, x.wdata, x.rd & ~x.wr, x.wr};
  endfunction

  task automatic driveIdle(input int k);
    m_read[k]    = 1'b0;
    m_write[k]   = 1'b0;
    m_address[k] = 27'($urandom);
    m_be[k]      = 2'($urandom);
    m_wdata[k]   = 16'($urandom);
  endtask

  task automatic driveXact(input int k, input xact_t x);
    m_read[k]    = x.rd;
    m_write[k]   = x.wr;
    m_address[k] = x.addr;
    m_be[k]      = x.be;
    m_wdata[k]   = x.wdata;
  endtask

  task automatic resetModel();
    owner = -1;
    strobe_cnt = 0;
    last_served = 1;
    for (int k = 0; k < 2; k++) begin
      active[k] = 1'b0;
      holdoff[k] = 0;
      req_drv[k] = 1'b0;
      exp_rdata[k] = 16'h0;
    end
  endtask

  // Compare one cycle of DUT behaviour against the transaction model.
  task automatic observeCycle();
    bit strobe = b_read | b_write;
    int w;
    if (owner != -1 && !strobe) checkOutput("ack_when_strobe_drops", m_ack[owner], 1);
    if (strobe && owner == -1) begin
      if (req_drv[0] && req_drv[1]) w = (last_served == 1) ? 0 : 1;
      else if (req_drv[0]) w = 0;
      else w = 1;
      owner = w;
      last_served = w;
      strobe_cnt = 1;
      served_order.push_back(w);
      checkOutput("bus_grant", {b_addr, b_be, b_wdata, b_read, b_write}, busOf(cur[w]));
    end else if (strobe) begin
      strobe_cnt++;
      checkOutput("bus_hold", {b_addr, b_be, b_wdata, b_read, b_write}, busOf(cur[owner]));
    end
    for (int k = 0; k < 2; k++) begin
      if (m_ack[k]) begin
        checkOutput("ack_owner", k, owner);
        if (owner == k) begin
          bit to = cur[k].delay > T;
          checkOutput("ack_error", m_err[k], to);
          checkOutput("strobe_cycles", strobe_cnt, to ? T : cur[k].delay);
          checkOutput("strobe_off_at_ack", strobe, 0);
          exp_rdata[k] = (to || cur[k].wr) ? 16'h0 : cur[k].rdata;
          owner = -1;
          active[k] = 1'b0;
          holdoff[k] = 1 + $urandom_range(0, max_gap);
        end
      end else begin
        checkOutput("error_without_ack", m_err[k], 0);
      end
      checkOutput("read_data", m_rdata[k], exp_rdata[k]);
    end
  endtask

  // Drive the bridge responder and both requesters for the next edge.
  task automatic applyStimulus();
    bit strobe = b_read | b_write;
    if (strobe && owner != -1 && strobe_cnt == cur[owner].delay) begin
      b_ack = 1'b1;
      b_rdata = cur[owner].rdata;
    end else begin
      b_ack = strobe ? 1'b0 : 1'($urandom_range(0, 3) == 0);
      b_rdata = 16'($urandom);
    end
    for (int k = 0; k < 2; k++) begin
      if (active[k]) begin
        if (owner == k) begin
          m_address[k] = 27'($urandom);
          m_be[k] = 2'($urandom);
          m_wdata[k] = 16'($urandom);
        end
      end else if (holdoff[k] > 0) begin
        holdoff[k]--;
        driveIdle(k);
      end else if (k == 0 && pend0.size() > 0) begin
        cur[0] = pend0.pop_front();
        driveXact(0, cur[0]);
        active[0] = 1'b1;
      end else if (k == 1 && pend1.size() > 0) begin
        cur[1] = pend1.pop_front();
        driveXact(1, cur[1]);
        active[1] = 1'b1;
      end else begin
        driveIdle(k);
      end
      req_drv[k] = m_read[k] | m_write[k];
    end
  endtask

  task automatic runTraffic(input int budget, input int gap);
    int cycles = 0;
    max_gap = gap;
    while ((pend0.size() + pend1.size() != 0 || active[0] || active[1] || owner != -1) && cycles < budget) begin
      @(negedge clk);
      cycles++;
      observeCycle();
      applyStimulus();
    end
    checkOutput("traffic_drained", pend0.size() + pend1.size() + int'(active[0]) + int'(active[1]), 0);
    @(negedge clk);
    observeCycle();
    applyStimulus();
  endtask

  task automatic resetMidBusy();
    int n = 0;
    b_ack = 1'b0;
    driveXact(0, mkXact(1'b1, 1'b0, 27'h2A5A5A5, 2'b11, 16'h0, 1000, 16'h0));
    while (!b_read && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reset_test_grant", b_read, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_bridge_read", b_read, 0);
    checkOutput("reset_bridge_outputs", {b_addr, b_be, b_read, b_write, b_wdata}, 0);
    checkOutput("reset_m_outputs", {m0_ack, m1_ack, m0_err, m1_err, m0_rd, m1_rd}, 0);
    driveIdle(0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_no_ack", m_ack, 0);
    end
    rst_n = 1'b1;
    resetModel();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    b_ack = 1'b0;
    b_rdata = 16'h0;
    driveIdle(0);
    driveIdle(1);
    resetModel();
    max_gap = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_bridge_outputs", {b_addr, b_be, b_read, b_write, b_wdata}, 0);
    checkOutput("reset_m_outputs", {m0_ack, m1_ack, m0_err, m1_err, m0_rd, m1_rd}, 0);
    rst_n = 1'b1;

    $display("[TB] contention after reset");
    served_order.delete();
    for (int i = 0; i < 3; i++) begin
      pend0.push_back(mkXact(1'b1, 1'b0, 27'(32'h100 + i), 2'b11, 16'h0, $urandom_range(1, 4), 16'($urandom)));
      pend1.push_back(mkXact(1'b0, 1'b1, 27'(32'h200 + i), 2'b10, 16'($urandom), $urandom_range(1, 4), 16'h0));
    end
    runTraffic(200, 0);
    checkOutput("rr_count", served_order.size(), 6);
    for (int i = 0; i < 4 && i < served_order.size(); i++) checkOutput("rr_order", served_order[i], i % 2);

    $display("[TB] m0 read returning 0xBEEF");
    pend0.push_back(mkXact(1'b1, 1'b0, 27'h0000100, 2'b11, 16'h0, 3, 16'hBEEF));
    runTraffic(50, 0);
    checkOutput("beef_read_data", m_rdata[0], 16'hBEEF);

    $display("[TB] m1 write timeout");
    pend1.push_back(mkXact(1'b0, 1'b1, 27'h0000040, 2'b01, 16'h1234, 1000, 16'h0));
    runTraffic(50, 0);

    $display("[TB] ack in timeout cycle");
    pend0.push_back(mkXact(1'b1, 1'b0, 27'h0000500, 2'b11, 16'h0, T, 16'hC0DE));
    runTraffic(50, 0);

    $display("[TB] read and write together");
    pend0.push_back(mkXact(1'b1, 1'b1, 27'h1234567, 2'b11, 16'hA55A, 5, 16'h7777));
    runTraffic(50, 0);

    $display("[TB] reset during transfer");
    resetMidBusy();
    pend1.push_back(mkXact(1'b1, 1'b0, 27'h0000321, 2'b11, 16'h0, 2, 16'h4321));
    runTraffic(50, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 30; i++) begin
      pend0.push_back(randXact());
      pend1.push_back(randXact());
    end
    runTraffic(3000, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bridge_arbiter.md
BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bridge cycles allowed per transfer before abort; legal range 2..65535.
REQ-002 SHALL have port clk_clk, input, 1: sole clock, all logic rising-edge.
REQ-003 SHALL have port reset_reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports m{0,1}_address, input, 27: requester word address.
REQ-005 SHALL have ports m{0,1}_byte_enable, input, 2: requester byte lanes.
REQ-006 SHALL have ports m{0,1}_read and m{0,1}_write, input, 1 each: request strobes, held until ack.
REQ-007 SHALL have ports m{0,1}_write_data, input, 16: write data.
REQ-008 SHALL have ports m{0,1}_acknowledge, output, 1: one-cycle completion pulse.
REQ-009 SHALL have ports m{0,1}_error, output, 1: qualifies acknowledge; 1 = timed out.
REQ-010 SHALL have ports m{0,1}_read_data, output, 16: read result, valid with acknowledge.
REQ-011 SHALL have ports bridge_memory_address (27), bridge_memory_byte_enable (2), bridge_memory_read (1), bridge_memory_write (1), bridge_memory_write_data (16), all outputs, driving the SDRAM bridge.
REQ-012 SHALL have ports bridge_memory_acknowledge (1) and bridge_memory_read_data (16), inputs, from the bridge.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 In IDLE, SHALL grant a requester whose read or write is high; if both request, grant the one not granted last (round-robin); last_grant resets to 1, so m0 wins first contention.
REQ-015 On grant in cycle N, SHALL register the winner's address, byte_enable, write_data and strobe onto bridge outputs, asserted from cycle N+1, and enter BUSY.
REQ-016 If a requester asserts read and write together, SHALL issue a write only.
REQ-017 Bridge outputs SHALL stay constant throughout BUSY, independent of requester input changes.
REQ-018 When bridge_memory_acknowledge is sampled high in BUSY at cycle K, SHALL in cycle K+1: deassert bridge read/write, pulse granted m*_acknowledge for exactly one cycle with m*_error=0, drive m*_read_data with read_data captured at K (0 for writes); state DONE.
REQ-019 DONE SHALL last exactly one cycle, then IDLE; no grant in DONE (requester drops its strobe during it).
REQ-020 SHALL count BUSY cycles from 1; when count reaches TIMEOUT_CYCLES with no ack, next cycle SHALL deassert bridge strobes, pulse m*_acknowledge with m*_error=1 and m*_read_data=0, enter DONE.
REQ-021 Ack and timeout in the same cycle: ack SHALL win (error=0, data returned).
REQ-022 Bridge ack outside BUSY SHALL be ignored.
REQ-023 Non-granted requester's acknowledge and error SHALL stay 0; its read_data SHALL hold its last value.
REQ-024 Minimum transfer period per requester SHALL be 4 cycles (grant, bridge ack, requester ack, DONE); back-to-back alternation SHALL achieve it.

Reset
REQ-025 While reset_reset_n is low, SHALL immediately force all outputs 0, state IDLE, timeout count 0, last_grant 1, including mid-transfer; no acknowledge is issued for an aborted transfer.
REQ-026 After reset release, first grant SHALL occur no earlier than the first rising edge with reset_reset_n high.

Structure
REQ-027 A shared package SHALL hold the state enum and constants ADDR_W=27, DATA_W=16, BE_W=2.
REQ-028 SHALL instantiate one sub-module, bridge_timeout_counter (clear, enable, terminal-count output, width from TIMEOUT_CYCLES).
REQ-029 All outputs SHALL be driven from registers.

Verification
REQ-030 m0 read addr 0x0000100, bridge acks 3 cycles after strobe with 0xBEEF -> m0_acknowledge one pulse, m0_read_data=0xBEEF, m0_error=0.
REQ-031 m0 and m1 request in same cycle after reset -> m0 served first, then m1; continued contention alternates m0,m1,m0.
REQ-032 m1 write 0x1234, byte_enable=2'b01, bridge never acks, TIMEOUT_CYCLES=8 -> bridge_memory_write high exactly 8 cycles, then m1_acknowledge with m1_error=1.
REQ-033 Ack arrives in timeout cycle (TIMEOUT_CYCLES=8, ack on 8th BUSY cycle) -> m*_error=0, data delivered.
REQ-034 reset_reset_n pulled low mid-BUSY -> bridge_memory_read low same cycle, no acknowledge; after release new m1 request served normally.
REQ-035 m0 read+write simultaneously with m0 address changing during BUSY -> bridge sees write only, address equals value at grant cycle.
